// File: rtl/alu_arb_pkg.sv
// Shared types and the ALU evaluation function for the ALU arbiter.
// Contents: XLEN, alu_op_e (ALUControl codes), alu_flags_t {n,z,c,v},
//           alu_out_t {result, flags}, alu_eval() combinational ALU.
package alu_arb_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        SLT = 3'b101
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        alu_flags_t      flags;
    } alu_out_t;

    // Single adder serves add, sub and slt; sub is A + ~B + 1 so carry means "no borrow".
    function automatic alu_out_t alu_eval(input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b,
                                          input logic [2:0]      op);
        alu_out_t        o;
        logic [XLEN-1:0] b_eff;
        logic [XLEN:0]   sum;
        o     = '0;
        b_eff = op[0] ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + (XLEN+1)'(op[0]);
        case (op)
            ADD, SUB: begin
                o.result  = sum[XLEN-1:0];
                o.flags.c = sum[XLEN];
                o.flags.v = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            AND:     o.result = a & b;
            OR:      o.result = a | b;
            SLT:     o.result = XLEN'(sum[XLEN-1]);
            default: o.result = '0;
        endcase
        o.flags.n = o.result[XLEN-1];
        o.flags.z = (o.result == '0);
        return o;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin priority search: grants the first set req bit at or above ptr,
// wrapping past N-1 to 0. Purely combinational.
// Ports: req (N), en (gate for the whole search), ptr (start index)
//        -> grant_c (one-hot), grant_idx_c (index), grant_valid_c.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] grant_idx_c,
    output logic          grant_valid_c
);

    int unsigned idx;

    // Walk N positions starting at ptr; first hit wins.
    always_comb begin
        grant_c       = '0;
        grant_idx_c   = '0;
        grant_valid_c = 1'b0;
        idx           = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (en && !grant_valid_c && req[idx]) begin
                grant_valid_c = 1'b1;
                grant_c[idx]  = 1'b1;
                grant_idx_c   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters: round-robin grant, valid/ready
// request handshake, single registered response slot with 1-cycle latency.
// Optional macro ALU_ARB_STATS_EN adds saturating grant/stall counters.
// Ports: clk, rst_n (async active-low)
//        req_valid/req_ready (N_REQ), req_a/req_b (N_REQ*XLEN), req_op (N_REQ*3)
//        rsp_valid, rsp_ready, rsp_id (ID_W), rsp_result (XLEN), rsp_flags {N,Z,C,V}
//        [ALU_ARB_STATS_EN] stat_grants (N_REQ*16), stat_stalls (16)
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*XLEN-1:0] req_a,
    input  logic [N_REQ*XLEN-1:0] req_b,
    input  logic [N_REQ*3-1:0]    req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [XLEN-1:0]       rsp_result,
    output logic [3:0]            rsp_flags
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]   stat_grants,
    output logic [15:0]           stat_stalls
`endif
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [XLEN-1:0] result_q, result_d;
    alu_flags_t      flags_q, flags_d;

    logic            can_accept;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_valid;
    logic [XLEN-1:0] alu_a, alu_b;
    logic [2:0]      alu_op;
    alu_out_t        alu_res;

    // Slot frees up this cycle if it is empty or being drained; rst_n keeps grants off in reset.
    assign can_accept = (state_q == EMPTY) || rsp_ready;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req           (req_valid),
        .en            (can_accept && rst_n),
        .ptr           (rr_ptr_q),
        .grant_c       (gnt),
        .grant_idx_c   (gnt_idx),
        .grant_valid_c (gnt_valid)
    );

    assign req_ready = gnt;

    // Operand mux from the granted lane; zeros when idle so nothing undefined reaches the ALU.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 3'b000;
        if (gnt_valid) begin
            alu_a  = req_a[32'(gnt_idx) * XLEN +: XLEN];
            alu_b  = req_b[32'(gnt_idx) * XLEN +: XLEN];
            alu_op = req_op[32'(gnt_idx) * 3 +: 3];
        end
    end

    assign alu_res = alu_eval(alu_a, alu_b, alu_op);

    // Slot FSM, slot capture and round-robin pointer advance.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            EMPTY: if (gnt_valid) state_d = FULL;
            FULL: begin
                if (gnt_valid)      state_d = FULL;
                else if (rsp_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (gnt_valid) begin
            id_d     = gnt_idx;
            result_d = alu_res.result;
            flags_d  = alu_res.flags;
            rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            id_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt_q [N_REQ];
    logic [15:0] stall_cnt_q;

    // Saturating per-lane accept counters and a stall counter (requests present, nothing granted).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_REQ); i++) grant_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (gnt[i] && (grant_cnt_q[i] != 16'hFFFF)) grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
            end
            if ((|req_valid) && !gnt_valid && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_stat
        assign stat_grants[g*16 +: 16] = grant_cnt_q[g];
    end
    assign stat_stalls = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (3 lanes to exercise non-power-of-two wrap).
// Expected responses are pushed to a queue at each modelled handshake and compared
// while the slot is modelled full; grants come from a reference round-robin model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned IW = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N*3-1:0]    req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [31:0]       rsp_result;
    logic [3:0]        rsp_flags;
`ifdef ALU_ARB_STATS_EN
    logic [N*16-1:0]   stat_grants;
    logic [15:0]       stat_stalls;
`endif

    alu_arbiter #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stalls(stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   res;
        logic [3:0]    fl;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic m_full  = 1'b0;
    int   m_ptr   = 0;
    int   m_grants[N];
    int   m_stalls = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference ALU: signed 64-bit arithmetic for overflow, unsigned compare for carry.
    function automatic logic [35:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [31:0] r, t;
        logic        c, v;
        longint      sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'b000: begin
                r = a + b;
                c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b001: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: begin
                t = a - b;
                r = {31'b0, t[31]};
            end
            default: r = 32'h0;
        endcase
        return {r, r[31], (r == 32'h0), c, v};
    endfunction

    task automatic set_lane(input int i, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] op);
        req_valid[i]        = v;
        req_a[i*32 +: 32]   = a;
        req_b[i*32 +: 32]   = b;
        req_op[i*3 +: 3]    = op;
    endtask

    // One clock: check outputs at negedge, update the model, return at posedge+1.
    task automatic tick();
        logic [N-1:0] eg;
        logic [35:0]  m;
        logic         can;
        int           gi;
        exp_t         e;
        @(negedge clk);
        can = rst_n && (!m_full || rsp_ready);
        check("rsp_valid", 64'(rsp_valid), 64'(m_full));
        if (m_full) begin
            check("sb_depth", 64'(q.size()), 64'd1);
            if (q.size() > 0) begin
                check("rsp_id", 64'(rsp_id), 64'(q[0].id));
                check("rsp_result", 64'(rsp_result), 64'(q[0].res));
                check("rsp_flags", 64'(rsp_flags), 64'(q[0].fl));
                if (rsp_ready) void'(q.pop_front());
            end
            if (rsp_ready) m_full = 1'b0;
        end
        eg = '0;
        gi = -1;
        if (can) begin
            for (int k = 0; k < int'(N); k++) begin
                int idx;
                idx = (m_ptr + k) % int'(N);
                if (gi < 0 && req_valid[idx]) gi = idx;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(eg));
        if (gi >= 0) begin
            m = model_alu(req_a[gi*32 +: 32], req_b[gi*32 +: 32], req_op[gi*3 +: 3]);
            e.id  = IW'(gi);
            e.res = m[35:4];
            e.fl  = m[3:0];
            q.push_back(e);
            m_full = 1'b1;
            m_ptr  = (gi + 1) % int'(N);
            m_grants[gi]++;
        end else if (rst_n && (|req_valid)) begin
            m_stalls++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < int'(N); i++) set_lane(i, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(N); i++) m_grants[i] = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: requests present but nothing granted, slot zeroed
        set_lane(0, 1'b1, 32'd1, 32'd1, 3'b000);
        set_lane(1, 1'b1, 32'd2, 32'd2, 3'b000);
        tick();
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_result", 64'(rsp_result), 64'd0);
        check("rst_flags", 64'(rsp_flags), 64'd0);
        idle_all();
        rst_n = 1'b1;
        tick();

        // Single lane 0 add 7+5
        rsp_ready = 1'b1;
        set_lane(0, 1'b1, 32'd7, 32'd5, 3'b000);
        tick();
        idle_all();
        tick();
        tick();

        // Lanes 0 and 1 every cycle: alternating grants, one response per cycle
        for (int c = 0; c < 8; c++) begin
            set_lane(0, 1'b1, $urandom, $urandom, 3'b000);
            set_lane(1, 1'b1, $urandom, $urandom, 3'b001);
            tick();
        end
        idle_all();
        tick();
        tick();

        // Subtraction edge cases
        set_lane(1, 1'b1, 32'h8000_0000, 32'd1, 3'b001);
        tick();
        set_lane(1, 1'b1, 32'd5, 32'd5, 3'b001);
        tick();
        set_lane(1, 1'b1, 32'd3, 32'd9, 3'b101);
        tick();
        idle_all();
        tick();
        tick();

        // Backpressure: slot held for 5 cycles, then drain and refill with no bubble
        rsp_ready = 1'b0;
        set_lane(2, 1'b1, 32'h0F0, 32'h00F, 3'b011);
        tick();
        idle_all();
        set_lane(0, 1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b010);
        repeat (5) tick();
        rsp_ready = 1'b1;
        tick();
        idle_all();
        tick();
        tick();

        // Reset while the slot is full
        rsp_ready = 1'b0;
        set_lane(1, 1'b1, 32'd1, 32'd2, 3'b000);
        tick();
        set_lane(0, 1'b1, 32'd4, 32'd4, 3'b000);
        set_lane(1, 1'b1, 32'd6, 32'd4, 3'b000);
        set_lane(2, 1'b1, 32'd8, 32'd4, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_id", 64'(rsp_id), 64'd0);
        check("arst_result", 64'(rsp_result), 64'd0);
        check("arst_flags", 64'(rsp_flags), 64'd0);
        check("arst_ready", 64'(req_ready), 64'd0);
        m_full = 1'b0;
        m_ptr  = 0;
        q.delete();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        idle_all();
        tick();
        tick();

        // Undefined op is still a normal transaction
        set_lane(0, 1'b1, 32'd3, 32'd4, 3'b111);
        tick();
        idle_all();
        tick();
        tick();

        // Random traffic: valids, ops and consumer backpressure all random
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                logic [31:0] a, b;
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                set_lane(i, 1'($urandom_range(0, 1)), a, b, 3'($urandom_range(0, 7)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        idle_all();
        rsp_ready = 1'b1;
        repeat (3) tick();
        check("sb_empty", 64'(q.size()), 64'd0);

`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < int'(N); i++)
            check("stat_grants", 64'(stat_grants[i*16 +: 16]), 64'(m_grants[i]));
        check("stat_stalls", 64'(stat_stalls), 64'(m_stalls));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
